// File: rtl/sync_pkg.sv
// sync_pkg: shared limits and helpers for the sync_edge_n input conditioner.  Rev 1.0
`default_nettype none

package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int DB_10MS_100MHZ  = 1000000;

  function automatic int db_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_chan.sv
// sync_edge_chan: one channel of synchroniser chain, optional debounce (SYNC_DEBOUNCE_EN) and edge pulses.  Rev 1.0
`default_nettype none

module sync_edge_chan
  import sync_pkg::*;
#(
  parameter int STAGES    = 3
`ifdef SYNC_DEBOUNCE_EN
  ,
  parameter int DB_CYCLES = DB_10MS_100MHZ
`endif
) (
  input  logic Clk100MHz,
  input  logic reset_n,
  input  logic async_sig,
  output logic sync_sig,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [STAGES-1:0] stage;
  logic              sync_raw;
  logic              next_sync;

  always_ff @(posedge Clk100MHz) begin
    if (!reset_n) stage <= '0;
    else          stage <= {stage[STAGES-2:0], async_sig};
  end

  assign sync_raw = stage[STAGES-1];

`ifdef SYNC_DEBOUNCE_EN
  localparam int            CW       = db_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] count;
  logic          sync_q;

  // Level is accepted only on the cycle the count reaches its last value.
  assign next_sync = (sync_raw != sync_q && count == CNT_LAST) ? sync_raw : sync_q;

  always_ff @(posedge Clk100MHz) begin
    if (!reset_n) begin
      count  <= '0;
      sync_q <= 1'b0;
    end else begin
      count  <= (sync_raw == sync_q || count == CNT_LAST) ? '0 : count + 1'b1;
      sync_q <= next_sync;
    end
  end

  assign sync_sig = sync_q;
`else
  // The last chain flop is the output; its D input lets the pulse land in the same edge.
  assign next_sync = stage[STAGES-2];
  assign sync_sig  = sync_raw;
`endif

  always_ff @(posedge Clk100MHz) begin
    if (!reset_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= ~sync_sig & next_sync;
      fall_pulse <= sync_sig & ~next_sync;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sync_edge_n.sv
// sync_edge_n: CH-channel synchroniser with rise/fall pulses; debounce built in with SYNC_DEBOUNCE_EN.  Rev 1.0
`default_nettype none

module sync_edge_n
  import sync_pkg::*;
#(
  parameter int CH        = 4,
  parameter int STAGES    = 3,
  parameter int DB_CYCLES = DB_10MS_100MHZ
) (
  input  logic          Clk100MHz,
  input  logic          reset_n,
  input  logic [CH-1:0] async_sig,
  output logic [CH-1:0] sync_sig,
  output logic [CH-1:0] rise_pulse,
  output logic [CH-1:0] fall_pulse,
  output logic          any_edge
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_edge_n: STAGES must be >= %0d", SYNC_MIN_STAGES);
  end
  if (CH < 1) begin : g_bad_ch
    $error("sync_edge_n: CH must be >= 1");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("sync_edge_n: DB_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    sync_edge_chan #(
      .STAGES    (STAGES)
`ifdef SYNC_DEBOUNCE_EN
      ,
      .DB_CYCLES (DB_CYCLES)
`endif
    ) u_chan (
      .Clk100MHz  (Clk100MHz),
      .reset_n    (reset_n),
      .async_sig  (async_sig[i]),
      .sync_sig   (sync_sig[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

  assign any_edge = |(rise_pulse | fall_pulse);

endmodule

`default_nettype wire
